// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencing controller.
//   fetch_state_e : controller FSM states (3-bit encoding)
//   redir_src_e   : redirect source (none, execute-stage, trap)
//   src_wins()    : true when an arriving source displaces a held one
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_EX   = 2'd1,
        SRC_TRAP = 2'd2
    } redir_src_e;

    // A trap always displaces; an execute redirect displaces anything but a
    // held trap (newest of equal priority wins).
    function automatic logic src_wins(input redir_src_e arr, input redir_src_e held);
        return (arr == SRC_TRAP) || ((arr == SRC_EX) && (held != SRC_TRAP));
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: handshake/control bundle between the hazard/execute/trap
// logic, fetch_ctrl and fetch_stage.
//   slave  : fetch_ctrl side (takes requests, drives fetch controls)
//   master : requester / observer side
interface fetch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic              stall_req;
    logic              ex_redirect_valid;
    logic [31:0]       ex_redirect_addr;
    logic              trap_valid;
    logic [31:0]       trap_vector;
    logic              btb_hit;
    logic              btb_taken;
    logic [31:0]       btb_target;
    logic              halt_req;
    logic              pc_en;
    logic              flush;
    logic              jump_en;
    logic [31:0]       pc_jump_addr;
    logic              btb_pc_valid;
    logic              btb_pc_predictTaken;
    logic [31:0]       btb_target_pc;
    logic              halted;
    logic [CNT_W-1:0]  redirect_cnt;

    modport slave (
        input  stall_req, ex_redirect_valid, ex_redirect_addr, trap_valid,
               trap_vector, btb_hit, btb_taken, btb_target, halt_req,
        output pc_en, flush, jump_en, pc_jump_addr, btb_pc_valid,
               btb_pc_predictTaken, btb_target_pc, halted, redirect_cnt
    );

    modport master (
        output stall_req, ex_redirect_valid, ex_redirect_addr, trap_valid,
               trap_vector, btb_hit, btb_taken, btb_target, halt_req,
        input  pc_en, flush, jump_en, pc_jump_addr, btb_pc_valid,
               btb_pc_predictTaken, btb_target_pc, halted, redirect_cnt
    );
endinterface

// File: rtl/fetch_redirect_arb.sv
// fetch_redirect_arb: priority select of redirect sources plus the single
// pending-redirect slot used while fetch is stalled.
//   clk, rst        : clock, async active-low reset
//   i_trap_*        : trap request and vector (highest priority)
//   i_ex_*          : execute-stage redirect request and target
//   i_pend_load     : merge this cycle's selection into the pending slot
//   i_pend_clr      : drop the pending slot (has priority over load)
//   o_arr_src/addr  : this cycle's winning arrival (combinational)
//   o_sel_src/addr  : arrival merged with the pending slot (combinational)
module fetch_redirect_arb
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_vector,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_addr,
    input  logic        i_pend_load,
    input  logic        i_pend_clr,
    output redir_src_e  o_arr_src,
    output logic [31:0] o_arr_addr,
    output redir_src_e  o_sel_src,
    output logic [31:0] o_sel_addr
);

    redir_src_e  r_pend_src;
    logic [31:0] r_pend_addr;

    always_comb begin
        o_arr_src  = SRC_NONE;
        o_arr_addr = '0;
        if (i_trap_valid) begin
            o_arr_src  = SRC_TRAP;
            o_arr_addr = i_trap_vector;
        end else if (i_ex_valid) begin
            o_arr_src  = SRC_EX;
            o_arr_addr = i_ex_addr;
        end
    end

    always_comb begin
        o_sel_src  = r_pend_src;
        o_sel_addr = r_pend_addr;
        if (src_wins(o_arr_src, r_pend_src)) begin
            o_sel_src  = o_arr_src;
            o_sel_addr = o_arr_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_src  <= SRC_NONE;
            r_pend_addr <= '0;
        end else if (i_pend_clr) begin
            r_pend_src  <= SRC_NONE;
            r_pend_addr <= '0;
        end else if (i_pend_load) begin
            r_pend_src  <= o_sel_src;
            r_pend_addr <= o_sel_addr;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequencing controller for fetch_stage. Holds fetch through
// boot, stalls, flush drain and halt; arbitrates trap / execute redirects;
// gates BTB predictions; counts accepted redirects (saturating).
//   clk, rst : clock, async active-low reset
//   bus      : fetch_ctrl_if.slave (requests in, fetch controls out)
// pc_en, flush, jump_en, pc_jump_addr and halted are registered; only the
// BTB gating is combinational from inputs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned BOOT_DELAY   = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    fetch_ctrl_if.slave bus
);

    localparam int unsigned BOOT_W  = $clog2(BOOT_DELAY + 1);
    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [BOOT_W-1:0]  BOOT_LAST  = BOOT_W'(BOOT_DELAY);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    fetch_state_e       r_state, w_state_nx;
    logic [BOOT_W-1:0]  r_boot_cnt, w_boot_nx;
    logic [FLUSH_W-1:0] r_flush_cnt, w_flush_nx;
    logic               r_pc_en, r_flush, r_jump_en, r_halted;
    logic [31:0]        r_pc_jump_addr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_jump;
    logic [31:0]        w_jump_addr;
    logic               w_pend_load, w_pend_clr;
    redir_src_e         w_arr_src, w_sel_src;
    logic [31:0]        w_arr_addr, w_sel_addr;

    fetch_redirect_arb u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_trap_valid  (bus.trap_valid),
        .i_trap_vector (bus.trap_vector),
        .i_ex_valid    (bus.ex_redirect_valid),
        .i_ex_addr     (bus.ex_redirect_addr),
        .i_pend_load   (w_pend_load),
        .i_pend_clr    (w_pend_clr),
        .o_arr_src     (w_arr_src),
        .o_arr_addr    (w_arr_addr),
        .o_sel_src     (w_sel_src),
        .o_sel_addr    (w_sel_addr)
    );

    // w_jump marks an accepted redirect: load target, (re)start the flush.
    always_comb begin
        w_state_nx  = r_state;
        w_boot_nx   = r_boot_cnt;
        w_flush_nx  = r_flush_cnt;
        w_jump      = 1'b0;
        w_pend_load = 1'b0;
        w_pend_clr  = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                if (r_boot_cnt == BOOT_LAST) w_state_nx = ST_RUN;
                else                         w_boot_nx  = r_boot_cnt + BOOT_W'(1);
            end
            ST_RUN: begin
                if (w_arr_src != SRC_NONE) w_jump     = 1'b1;
                else if (bus.stall_req)    w_state_nx = ST_STALL;
                else if (bus.halt_req)     w_state_nx = ST_HALT;
            end
            ST_STALL: begin
                // An arrival in the release cycle merges with the slot
                // before the exit decision.
                if (bus.stall_req) begin
                    w_pend_load = 1'b1;
                end else begin
                    w_pend_clr = 1'b1;
                    if (w_sel_src != SRC_NONE) w_jump     = 1'b1;
                    else                       w_state_nx = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (w_arr_src != SRC_NONE) w_jump = 1'b1;
                else if (r_flush_cnt == '0)
                    w_state_nx = bus.halt_req ? ST_HALT : ST_RUN;
                else
                    w_flush_nx = r_flush_cnt - FLUSH_W'(1);
            end
            ST_HALT: begin
                if (w_arr_src == SRC_TRAP) w_jump     = 1'b1;
                else if (!bus.halt_req)    w_state_nx = ST_RUN;
            end
            default: w_state_nx = ST_BOOT;
        endcase
        w_jump_addr = (r_state == ST_STALL) ? w_sel_addr : w_arr_addr;
        if (w_jump) begin
            w_state_nx = ST_FLUSH;
            w_flush_nx = FLUSH_LAST;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_BOOT;
            r_boot_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_boot_cnt  <= w_boot_nx;
            r_flush_cnt <= w_flush_nx;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc_en        <= 1'b0;
            r_flush        <= 1'b0;
            r_jump_en      <= 1'b0;
            r_halted       <= 1'b0;
            r_pc_jump_addr <= '0;
            r_cnt          <= '0;
        end else begin
            r_pc_en   <= (w_state_nx == ST_RUN) || w_jump;
            r_flush   <= (w_state_nx == ST_FLUSH);
            r_jump_en <= w_jump;
            r_halted  <= (w_state_nx == ST_HALT);
            if (w_jump) r_pc_jump_addr <= w_jump_addr;
            if (w_jump && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.pc_en               = r_pc_en;
    assign bus.flush               = r_flush;
    assign bus.jump_en             = r_jump_en;
    assign bus.pc_jump_addr        = r_pc_jump_addr;
    assign bus.halted              = r_halted;
    assign bus.redirect_cnt        = r_cnt;
    assign bus.btb_pc_valid        = bus.btb_hit & (r_state == ST_RUN) & ~bus.stall_req
                                     & ~bus.trap_valid & ~bus.ex_redirect_valid;
    assign bus.btb_pc_predictTaken = bus.btb_pc_valid & bus.btb_taken;
    assign bus.btb_target_pc       = bus.btb_target;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plan steps followed by randomized traffic, all
// checked against a cycle-level behavioural model of the controller.
module tb_fetch_ctrl;

    localparam int unsigned BD = 4;
    localparam int unsigned FC = 2;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.CNT_W(CW)) bus ();

    fetch_ctrl #(.BOOT_DELAY(BD), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_fail  = 0;

    // behavioural model
    bit          m_booting;
    int unsigned m_boot_seen;
    int unsigned m_flush_left;
    bit          m_stalled, m_halted, m_jump;
    bit          m_pend_v, m_pend_trap;
    logic [31:0] m_pend_addr, m_addr;
    int unsigned m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_booting    = 1'b1;
        m_boot_seen  = 0;
        m_flush_left = 0;
        m_stalled    = 1'b0;
        m_halted     = 1'b0;
        m_jump       = 1'b0;
        m_pend_v     = 1'b0;
        m_pend_trap  = 1'b0;
        m_pend_addr  = '0;
        m_addr       = '0;
        m_cnt        = 0;
    endtask

    function automatic bit m_in_run();
        return !m_booting && (m_flush_left == 0) && !m_halted && !m_stalled;
    endfunction

    task automatic model_edge();
        bit          take;
        bit          arr;
        logic [31:0] tgt;
        logic [31:0] arr_addr;
        take     = 1'b0;
        tgt      = '0;
        arr      = bus.trap_valid || bus.ex_redirect_valid;
        arr_addr = bus.trap_valid ? bus.trap_vector : bus.ex_redirect_addr;
        if (m_booting) begin
            m_boot_seen++;
            if (m_boot_seen == BD + 1) m_booting = 1'b0;
        end else if (m_flush_left > 0) begin
            if (arr) begin
                take = 1'b1;
                tgt  = arr_addr;
            end else begin
                m_flush_left--;
                if ((m_flush_left == 0) && bus.halt_req) m_halted = 1'b1;
            end
        end else if (m_halted) begin
            if (bus.trap_valid) begin
                take = 1'b1;
                tgt  = bus.trap_vector;
            end else if (!bus.halt_req) begin
                m_halted = 1'b0;
            end
        end else if (m_stalled) begin
            if (bus.trap_valid || (bus.ex_redirect_valid && !(m_pend_v && m_pend_trap))) begin
                m_pend_v    = 1'b1;
                m_pend_trap = bus.trap_valid;
                m_pend_addr = arr_addr;
            end
            if (!bus.stall_req) begin
                m_stalled = 1'b0;
                if (m_pend_v) begin
                    take = 1'b1;
                    tgt  = m_pend_addr;
                end
                m_pend_v = 1'b0;
            end
        end else begin
            if (arr) begin
                take = 1'b1;
                tgt  = arr_addr;
            end else if (bus.stall_req) begin
                m_stalled = 1'b1;
            end else if (bus.halt_req) begin
                m_halted = 1'b1;
            end
        end
        m_jump = take;
        if (take) begin
            m_flush_left = FC;
            m_halted     = 1'b0;
            m_addr       = tgt;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
    endtask

    task automatic check_regs();
        chk("pc_en", 32'(bus.pc_en),
            32'(!m_booting && !m_halted && !m_stalled && ((m_flush_left == 0) || m_jump)));
        chk("flush", 32'(bus.flush), 32'(m_flush_left > 0));
        chk("jump_en", 32'(bus.jump_en), 32'(m_jump));
        chk("pc_jump_addr", bus.pc_jump_addr, m_addr);
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("redirect_cnt", 32'(bus.redirect_cnt), m_cnt);
    endtask

    task automatic check_btb();
        bit v;
        v = bus.btb_hit && m_in_run() && !bus.stall_req && !bus.trap_valid
            && !bus.ex_redirect_valid;
        chk("btb_pc_valid", 32'(bus.btb_pc_valid), 32'(v));
        chk("btb_pc_predictTaken", 32'(bus.btb_pc_predictTaken), 32'(v && bus.btb_taken));
        chk("btb_target_pc", bus.btb_target_pc, bus.btb_target);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_btb();
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    initial begin
        bus.stall_req         = 1'b0;
        bus.ex_redirect_valid = 1'b0;
        bus.ex_redirect_addr  = '0;
        bus.trap_valid        = 1'b0;
        bus.trap_vector       = '0;
        bus.btb_hit           = 1'b0;
        bus.btb_taken         = 1'b0;
        bus.btb_target        = 32'hCAFE_0010;
        bus.halt_req          = 1'b0;
        model_reset();

        // reset state, also across a clock edge
        #2;
        check_regs();
        @(posedge clk);
        #1;
        check_regs();
        rst = 1'b1;

        // boot: BD cycles with pc_en low, BTB blocked
        bus.btb_hit   = 1'b1;
        bus.btb_taken = 1'b1;
        for (int i = 0; i < int'(BD); i++) begin
            cycle();
            chk("boot_pc_en_low", 32'(bus.pc_en), 32'd0);
        end
        chk("btb_valid_boot", 32'(bus.btb_pc_valid), 32'd0);
        cycle();
        chk("boot_pc_en_high", 32'(bus.pc_en), 32'd1);

        // BTB gating in RUN
        #1;
        chk("btb_valid_run", 32'(bus.btb_pc_valid), 32'd1);
        chk("btb_taken_run", 32'(bus.btb_pc_predictTaken), 32'd1);
        bus.stall_req = 1'b1;
        #1;
        chk("btb_valid_stall", 32'(bus.btb_pc_valid), 32'd0);
        chk("btb_taken_stall", 32'(bus.btb_pc_predictTaken), 32'd0);
        bus.stall_req = 1'b0;
        bus.btb_taken = 1'b0;
        #1;
        chk("btb_taken_not", 32'(bus.btb_pc_predictTaken), 32'd0);
        bus.btb_hit = 1'b0;

        // execute redirect
        bus.ex_redirect_valid = 1'b1;
        bus.ex_redirect_addr  = 32'h100;
        cycle();
        bus.ex_redirect_valid = 1'b0;
        chk("redir_jump", 32'(bus.jump_en), 32'd1);
        chk("redir_addr", bus.pc_jump_addr, 32'h100);
        chk("redir_flush1", 32'(bus.flush), 32'd1);
        chk("redir_cnt", 32'(bus.redirect_cnt), 32'd1);
        cycle();
        chk("redir_flush2", 32'(bus.flush), 32'd1);
        chk("redir_pc_en2", 32'(bus.pc_en), 32'd0);
        cycle();
        chk("redir_flush_done", 32'(bus.flush), 32'd0);

        // priority: trap beats execute redirect
        bus.trap_valid        = 1'b1;
        bus.trap_vector       = 32'h80;
        bus.ex_redirect_valid = 1'b1;
        bus.ex_redirect_addr  = 32'h200;
        cycle();
        bus.trap_valid        = 1'b0;
        bus.ex_redirect_valid = 1'b0;
        chk("prio_addr", bus.pc_jump_addr, 32'h80);
        chk("prio_cnt", 32'(bus.redirect_cnt), 32'd2);
        cycle();
        cycle();

        // stall with a redirect arriving in its second cycle
        bus.stall_req = 1'b1;
        cycle();
        chk("stall_pc_en1", 32'(bus.pc_en), 32'd0);
        bus.ex_redirect_valid = 1'b1;
        bus.ex_redirect_addr  = 32'h40;
        cycle();
        bus.ex_redirect_valid = 1'b0;
        chk("stall_pc_en2", 32'(bus.pc_en), 32'd0);
        chk("stall_no_jump", 32'(bus.jump_en), 32'd0);
        cycle();
        chk("stall_pc_en3", 32'(bus.pc_en), 32'd0);
        bus.stall_req = 1'b0;
        cycle();
        chk("pend_jump", 32'(bus.jump_en), 32'd1);
        chk("pend_addr", bus.pc_jump_addr, 32'h40);
        cycle();
        cycle();

        // halt requested during a flush
        bus.ex_redirect_valid = 1'b1;
        bus.ex_redirect_addr  = 32'h300;
        cycle();
        bus.ex_redirect_valid = 1'b0;
        bus.halt_req          = 1'b1;
        cycle();
        chk("halt_during_flush", 32'(bus.halted), 32'd0);
        cycle();
        chk("halt_entered", 32'(bus.halted), 32'd1);
        chk("halt_pc_en", 32'(bus.pc_en), 32'd0);
        bus.ex_redirect_valid = 1'b1;
        cycle();
        bus.ex_redirect_valid = 1'b0;
        chk("halt_ignores_ex", 32'(bus.jump_en), 32'd0);

        // trap out of halt
        bus.trap_valid  = 1'b1;
        bus.trap_vector = 32'h80;
        cycle();
        bus.trap_valid = 1'b0;
        chk("halt_trap_jump", 32'(bus.jump_en), 32'd1);
        chk("halt_trap_addr", bus.pc_jump_addr, 32'h80);
        chk("halt_trap_halted", 32'(bus.halted), 32'd0);
        bus.halt_req = 1'b0;
        cycle();
        cycle();
        cycle();

        // new redirect during flush restarts it
        bus.ex_redirect_valid = 1'b1;
        bus.ex_redirect_addr  = 32'h500;
        cycle();
        bus.ex_redirect_valid = 1'b0;
        bus.trap_valid        = 1'b1;
        bus.trap_vector       = 32'h600;
        cycle();
        bus.trap_valid = 1'b0;
        chk("restart_jump", 32'(bus.jump_en), 32'd1);
        chk("restart_addr", bus.pc_jump_addr, 32'h600);
        cycle();
        chk("restart_flush2", 32'(bus.flush), 32'd1);
        cycle();
        chk("restart_done", 32'(bus.flush), 32'd0);

        // asynchronous reset in the middle of a flush
        bus.ex_redirect_valid = 1'b1;
        bus.ex_redirect_addr  = 32'h700;
        cycle();
        bus.ex_redirect_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_addr", bus.pc_jump_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // randomized traffic (includes a fresh boot and counter saturation)
        for (int i = 0; i < 600; i++) begin
            bus.stall_req         = ($urandom_range(0, 99) < 25);
            bus.ex_redirect_valid = ($urandom_range(0, 99) < 15);
            bus.ex_redirect_addr  = $urandom() & 32'hFFFF_FFFC;
            bus.trap_valid        = ($urandom_range(0, 99) < 8);
            bus.trap_vector       = $urandom() & 32'hFFFF_FFFC;
            bus.halt_req          = ($urandom_range(0, 99) < 20);
            bus.btb_hit           = ($urandom_range(0, 1) == 1);
            bus.btb_taken         = ($urandom_range(0, 1) == 1);
            bus.btb_target        = $urandom();
            cycle();
        end
        chk("cnt_saturated", 32'(bus.redirect_cnt), 32'((1 << CW) - 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
